// File: rtl/spi_mem_master.sv
// SPI mode-0 master that issues READ (0x03) / WRITE (0x02) frames to a serial memory:
// command, address (most-significant byte first), then data bytes (byte 0 first), MSB first in each byte.
module spi_mem_master #(
  parameter int ADDR_BITS  = 24,
  parameter int DATA_BYTES = 4,
  parameter int CLK_DIV    = 1,
  localparam int LEN_W     = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_BITS-1:0]    req_addr,
  input  logic [LEN_W-1:0]        req_len,
  input  logic [8*DATA_BYTES-1:0] req_wdata,
  output logic                    done,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
  output logic                    cs
);

  localparam int DW      = 8 * DATA_BYTES;
  localparam int FRAME_W = 8 + ADDR_BITS + DW;
  localparam int IDX_W   = 7;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RD_IW   = $clog2(DW);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [FRAME_W-1:0] sh_r, sh_s, frame_s;
  logic [IDX_W-1:0]   idx_r, idx_s, last_r, last_s, rel_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [LEN_W-1:0]   len_sat_s;
  logic [RD_IW-1:0]   rd_idx_s;
  logic               write_r, write_s;
  logic               sclk_r, sclk_s, mosi_r, mosi_s, cs_r, cs_s;
  logic               done_r, done_s, ready_r, ready_s;
  logic [DW-1:0]      rdata_r, rdata_s;

  assign req_ready = ready_r;
  assign done      = done_r;
  assign rdata     = rdata_r;
  assign sclk      = sclk_r;
  assign mosi      = mosi_r;
  assign cs        = cs_r;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_s = state_r;
    sh_s    = sh_r;
    idx_s   = idx_r;
    last_s  = last_r;
    div_s   = div_r;
    write_s = write_r;
    sclk_s  = sclk_r;
    mosi_s  = mosi_r;
    cs_s    = cs_r;
    done_s  = 1'b0;
    ready_s = ready_r;
    rdata_s = rdata_r;

    len_sat_s = (req_len > LEN_W'(DATA_BYTES - 1)) ? LEN_W'(DATA_BYTES - 1) : req_len;
    frame_s   = {FRAME_W{1'b0}};
    frame_s[FRAME_W-1 -: 8]   = req_write ? 8'h02 : 8'h03;
    frame_s[DW +: ADDR_BITS]  = req_addr;
    // Data field is byte 0 first; reads shift out zeros during the data phase.
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (req_write) begin
        frame_s[DW-8-8*k +: 8] = req_wdata[8*k +: 8];
      end else begin
        frame_s[DW-8-8*k +: 8] = 8'h00;
      end
    end

    rel_s    = idx_r - IDX_W'(8 + ADDR_BITS);
    rd_idx_s = RD_IW'({rel_s[IDX_W-1:3], ~rel_s[2:0]});

    case (state_r)
      IDLE: begin
        if (req_valid && ready_r) begin
          state_s = CMD;
          write_s = req_write;
          sh_s    = {frame_s[FRAME_W-2:0], 1'b0};
          mosi_s  = frame_s[FRAME_W-1];
          idx_s   = {IDX_W{1'b0}};
          last_s  = IDX_W'(ADDR_BITS + 15) + IDX_W'({len_sat_s, 3'b000});
          div_s   = {DIV_W{1'b0}};
          sclk_s  = 1'b0;
          cs_s    = 1'b0;
          rdata_s = {DW{1'b0}};
          ready_s = 1'b0;
        end else begin
          ready_s = 1'b1;
        end
      end
      CMD, ADDR, DATA: begin
        cs_s = 1'b0;
        if (div_r != DIV_W'(CLK_DIV - 1)) begin
          div_s = div_r + DIV_W'(1);
        end else begin
          div_s = {DIV_W{1'b0}};
          if (!sclk_r) begin
            sclk_s = 1'b1;
            if (state_r == DATA && !write_r) begin
              rdata_s[rd_idx_s] = miso;
            end else begin
              rdata_s = rdata_r;
            end
          end else if (idx_r == last_r) begin
            state_s = DONE;
            sclk_s  = 1'b0;
            mosi_s  = 1'b0;
            cs_s    = 1'b1;
            done_s  = 1'b1;
          end else begin
            sclk_s = 1'b0;
            mosi_s = sh_r[FRAME_W-1];
            sh_s   = {sh_r[FRAME_W-2:0], 1'b0};
            idx_s  = idx_r + IDX_W'(1);
            if (idx_s == IDX_W'(8)) begin
              state_s = ADDR;
            end else if (idx_s == IDX_W'(8 + ADDR_BITS)) begin
              state_s = DATA;
            end else begin
              state_s = state_r;
            end
          end
        end
      end
      DONE: begin
        state_s = IDLE;
        ready_s = 1'b1;
      end
      default: begin
        state_s = IDLE;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
        cs_s    = 1'b1;
        ready_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the bus idle immediately, even mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sh_r    <= {FRAME_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      last_r  <= {IDX_W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
      write_r <= 1'b0;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
      cs_r    <= 1'b1;
      done_r  <= 1'b0;
      ready_r <= 1'b0;
      rdata_r <= {DW{1'b0}};
    end else begin
      state_r <= state_s;
      sh_r    <= sh_s;
      idx_r   <= idx_s;
      last_r  <= last_s;
      div_r   <= div_s;
      write_r <= write_s;
      sclk_r  <= sclk_s;
      mosi_r  <= mosi_s;
      cs_r    <= cs_s;
      done_r  <= done_s;
      ready_r <= ready_s;
      rdata_r <= rdata_s;
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
// Scoreboard bench for spi_mem_master: two instances (CLK_DIV 1 and 3) each with a serial-memory slave model.
module tb_spi_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid[2], req_ready[2], req_write[2], done[2], sclk[2], mosi[2], cs[2];
  logic        miso[2] = '{1'b0, 1'b0};
  logic [23:0] req_addr[2];
  logic [1:0]  req_len[2];
  logic [31:0] req_wdata[2], rdata[2];

  always #5 clk = ~clk;

  spi_mem_master #(.ADDR_BITS(24), .DATA_BYTES(4), .CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_len(req_len[0]),
    .req_wdata(req_wdata[0]), .done(done[0]), .rdata(rdata[0]), .sclk(sclk[0]),
    .mosi(mosi[0]), .miso(miso[0]), .cs(cs[0]));

  spi_mem_master #(.ADDR_BITS(24), .DATA_BYTES(4), .CLK_DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_len(req_len[1]),
    .req_wdata(req_wdata[1]), .done(done[1]), .rdata(rdata[1]), .sclk(sclk[1]),
    .mosi(mosi[1]), .miso(miso[1]), .cs(cs[1]));

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic [71:0] mosi_hdr;
    int          mbits;
    int          nbits;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   ntot = 0;
  int   nbad = 0;
  int   cyc  = 0;

  int          acc_edge[2]  = '{0, 0};
  int          rise_edge[2] = '{0, 0};
  int          gap[2]       = '{0, 0};
  int          last_gap[2]  = '{0, 0};
  int          run[2]       = '{0, 0};
  int          done_cnt[2]  = '{0, 0};
  logic        ph_err[2]    = '{1'b0, 1'b0};
  logic        cs_m[2]      = '{1'b1, 1'b1};
  logic        sclk_m[2]    = '{1'b0, 1'b0};
  int          bitcnt[2]    = '{0, 0};
  int          rises[2]     = '{0, 0};
  logic [71:0] mlog[2]      = '{72'h0, 72'h0};
  logic [31:0] resp[2]      = '{32'h0, 32'h0};
  logic        cs_q[2]      = '{1'b1, 1'b1};
  logic        sclk_q[2]    = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    ntot++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave miso for frame bit b: header bits drive 1 so stray sampling shows up in rdata.
  function automatic logic sbit(input logic [31:0] r, input int b);
    int j;
    j = b - 32;
    if (j < 0 || j >= 32) return 1'b1;
    return r[8*(j/8) + 7 - (j%8)];
  endfunction

  function automatic int div_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  always @(posedge clk) cyc++;

  // Serial memory slave: logs mosi on sclk rise, presents the next miso bit on sclk fall.
  always @(cs[0], cs[1], sclk[0], sclk[1]) begin
    for (int g = 0; g < 2; g++) begin
      if (!cs[g] && cs_q[g]) begin
        bitcnt[g] = 0;
        rises[g]  = 0;
        mlog[g]   = 72'h0;
        miso[g]   = sbit(resp[g], 0);
      end else if (!cs[g] && sclk[g] && !sclk_q[g]) begin
        mlog[g] = {mlog[g][70:0], mosi[g]};
        bitcnt[g]++;
        rises[g]++;
      end else if (!cs[g] && !sclk[g] && sclk_q[g]) begin
        miso[g] = sbit(resp[g], bitcnt[g]);
      end
      cs_q[g]   = cs[g];
      sclk_q[g] = sclk[g];
    end
  end

  // Monitor: tracks accepts, sclk phase lengths and cs gaps; pops the scoreboard on every done.
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      if (req_valid[g] && req_ready[g]) acc_edge[g] = cyc + 1;
      if (!cs[g]) begin
        if (cs_m[g]) begin
          last_gap[g] = gap[g];
          run[g]      = 1;
          ph_err[g]   = 1'b0;
        end else if (sclk[g] == sclk_m[g]) begin
          run[g]++;
        end else begin
          if (run[g] != div_of(g)) ph_err[g] = 1'b1;
          run[g] = 1;
        end
        gap[g] = 0;
      end else begin
        if (!cs_m[g]) begin
          rise_edge[g] = cyc;
          if (run[g] != div_of(g)) ph_err[g] = 1'b1;
        end
        gap[g]++;
      end
      cs_m[g]   = cs[g];
      sclk_m[g] = sclk[g];
      if (done[g]) begin
        done_cnt[g]++;
        if (exp_q.size() == 0) begin
          ntot++;
          nbad++;
          $display("FAIL unexpected_done: got done on dut%0d expected none", g);
        end else begin
          e = exp_q.pop_front();
          check("dut_id", 72'(g), 72'(e.dut));
          check("rdata", 72'(rdata[g]), 72'(e.rdata));
          check("mosi_stream", mlog[g] >> (e.nbits - e.mbits), e.mosi_hdr);
          check("sclk_rises", 72'(rises[g]), 72'(e.nbits));
          check("done_latency", 72'(cyc + 1 - acc_edge[g]), 72'(e.lat));
          check("sclk_phase_len", 72'(ph_err[g]), 72'(0));
        end
      end
    end
  end

  task automatic wait_accept(input int g);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready[g]) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    ntot++;
    nbad++;
    $display("FAIL accept_timeout: got no req_ready on dut%0d expected accept", g);
  endtask

  task automatic send(input int g, input logic w, input logic [23:0] a, input logic [1:0] l,
                      input logic [31:0] wd);
    @(posedge clk);
    #1;
    req_write[g] = w;
    req_addr[g]  = a;
    req_len[g]   = l;
    req_wdata[g] = wd;
    req_valid[g] = 1'b1;
    wait_accept(g);
    req_valid[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int cnt);
    int start;
    start = done_cnt[g];
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_cnt[g] >= start + cnt) return;
    end
    ntot++;
    nbad++;
    $display("FAIL done_timeout: got %0d done pulses on dut%0d expected %0d", done_cnt[g] - start, g, cnt);
  endtask

  task automatic check_idle_reset(input int g);
    check("rst_cs", 72'(cs[g]), 72'(1));
    check("rst_sclk", 72'(sclk[g]), 72'(0));
    check("rst_done", 72'(done[g]), 72'(0));
    check("rst_ready", 72'(req_ready[g]), 72'(0));
    check("rst_rdata", 72'(rdata[g]), 72'(0));
    check("rst_mosi", 72'(mosi[g]), 72'(0));
  endtask

  initial begin
    int nd;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0;
      req_write[g] = 1'b0;
      req_addr[g]  = 24'h0;
      req_len[g]   = 2'd0;
      req_wdata[g] = 32'h0;
    end

    // Power-on reset, then release: ready rises exactly one edge later.
    #12;
    check_idle_reset(0);
    check_idle_reset(1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_edge", 72'(req_ready[0]), 72'(0));
    @(posedge clk);
    #1;
    check("ready_after_edge0", 72'(req_ready[0]), 72'(1));
    check("ready_after_edge1", 72'(req_ready[1]), 72'(1));

    // Reset while idle drops ready immediately.
    #2;
    rst = 1'b1;
    #1;
    check("idle_rst_ready", 72'(req_ready[0]), 72'(0));
    check("idle_rst_cs", 72'(cs[0]), 72'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rst_ready_back", 72'(req_ready[0]), 72'(1));

    // Read 1 byte, CLK_DIV=1: N=40 bits, done at T+81.
    resp[0] = 32'hFFFF_FFA5;
    exp_q.push_back('{0, 32'h0000_00A5, 72'h0301_2345, 32, 40, 81});
    send(0, 1'b0, 24'h01_2345, 2'd0, 32'h0);
    wait_done(0, 1);

    // Write 4 bytes: miso ignored, byte 0 first on the wire, done at T+129.
    resp[0] = 32'hFFFF_FFFF;
    exp_q.push_back('{0, 32'h0, 72'h0200_0010_EFBE_ADDE, 64, 64, 129});
    send(0, 1'b1, 24'h00_0010, 2'd3, 32'hDEAD_BEEF);
    wait_done(0, 1);

    // Read 2 bytes, CLK_DIV=3: bytes above req_len stay 0, done at T+289.
    resp[1] = 32'hFFFF_1234;
    exp_q.push_back('{1, 32'h0000_1234, 72'h0300_ABCD, 32, 48, 289});
    send(1, 1'b0, 24'h00_ABCD, 2'd1, 32'h0);
    wait_done(1, 1);

    // Back-to-back reads with req_valid held high.
    resp[0] = 32'h0000_005A;
    exp_q.push_back('{0, 32'h0000_005A, 72'h0300_0100, 32, 40, 81});
    exp_q.push_back('{0, 32'h0000_005A, 72'h0300_0200, 32, 40, 81});
    nd = done_cnt[0];
    @(posedge clk);
    #1;
    req_write[0] = 1'b0;
    req_addr[0]  = 24'h00_0100;
    req_len[0]   = 2'd0;
    req_valid[0] = 1'b1;
    wait_accept(0);
    req_addr[0] = 24'h00_0200;
    wait_accept(0);
    req_valid[0] = 1'b0;
    check("b2b_accept_after_cs_rise", 72'(acc_edge[0] - rise_edge[0]), 72'(2));
    wait_done(0, 2 - (done_cnt[0] - nd));
    check("b2b_done_pulses", 72'(done_cnt[0] - nd), 72'(2));
    check("b2b_cs_gap", 72'(last_gap[0]), 72'(2));

    // Reset during data byte 1 of a 4-byte read: no done, bus idle at once.
    resp[0] = 32'h1122_3344;
    send(0, 1'b0, 24'h00_0040, 2'd3, 32'h0);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bitcnt[0] >= 43) break;
    end
    #2;
    rst = 1'b1;
    #1;
    check_idle_reset(0);
    nd = done_cnt[0];
    repeat (3) @(negedge clk);
    check("abort_no_done", 72'(done_cnt[0] - nd), 72'(0));
    rst = 1'b0;

    // Next request after the abort completes normally.
    resp[0] = 32'h0000_00C3;
    exp_q.push_back('{0, 32'h0000_00C3, 72'h0300_0123, 32, 40, 81});
    send(0, 1'b0, 24'h00_0123, 2'd0, 32'h0);
    wait_done(0, 1);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 72'(exp_q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
